// File: rtl/reg_bank_n.sv
// reg_bank_n: NCH x WIDTH register bank with masked load,
// shift chain, clear and a registered addressed readback.
module reg_bank_n #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NCH = 4,
  parameter int unsigned AW = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [1:0]         Mode,
  input  logic [NCH-1:0]     LoadEn,
  input  logic [NCH*WIDTH-1:0] DataIn,
  input  logic [WIDTH-1:0]   ShiftIn,
  input  logic               RdReq,
  input  logic [AW-1:0]      RdAddr,
  output logic [NCH*WIDTH-1:0] Regs,
  output logic [WIDTH-1:0]   ShiftOut,
  output logic [WIDTH-1:0]   RdData,
  output logic               RdValid,
  output logic               AddrErr
);

  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    CLEAR = 2'b11
  } mode_e;

  localparam logic [AW:0] NCH_W = (AW+1)'(NCH);

  logic [WIDTH-1:0] ch [NCH];
  logic [WIDTH-1:0] rd_word;
  logic             addr_ok;
  mode_e            mode;

  assign mode = mode_e'(Mode);

  // Channel storage: update all channels according to mode
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NCH; i++) ch[i] <= RESET_VAL;
    end else begin
      case (mode)
        LOAD: begin
          for (int i = 0; i < NCH; i++)
            if (LoadEn[i]) ch[i] <= DataIn[i*WIDTH +: WIDTH];
        end
        SHIFT: begin
          ch[0] <= ShiftIn;
          for (int i = 1; i < NCH; i++) ch[i] <= ch[i-1];
        end
        CLEAR: begin
          for (int i = 0; i < NCH; i++) ch[i] <= RESET_VAL;
        end
        default: ;
      endcase
    end
  end

  // Parallel view straight from the flops
  always_comb begin
    Regs = '0;
    for (int i = 0; i < NCH; i++) Regs[i*WIDTH +: WIDTH] = ch[i];
  end

  assign ShiftOut = ch[NCH-1];
  assign addr_ok  = {1'b0, RdAddr} < NCH_W;

  // Readback mux over the pre-update channel values
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NCH; i++)
      if (RdAddr == AW'(i)) rd_word = ch[i];
  end

  // Registered readback with one-cycle valid/error pulses
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      RdData  <= '0;
      RdValid <= 1'b0;
      AddrErr <= 1'b0;
    end else begin
      RdValid <= RdReq;
      AddrErr <= RdReq & ~addr_ok;
      if (RdReq) RdData <= addr_ok ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_reg_bank_n.sv
// tb_reg_bank_n: directed + random checks of reg_bank_n
// against an array model, for NCH=4 and NCH=3 instances.
module tb_reg_bank_n;

  logic        Clk;
  logic        Rst;
  logic [1:0]  Mode;
  logic [3:0]  LoadEn;
  logic [15:0] DataIn;
  logic [3:0]  ShiftIn;
  logic        RdReq;
  logic [1:0]  RdAddr;

  logic [15:0] regs4;
  logic [3:0]  so4, rd4;
  logic        rv4, ae4;
  logic [11:0] regs3;
  logic [3:0]  so3, rd3;
  logic        rv3, ae3;

  int nvec = 0;
  int nerr = 0;

  int nch [2] = '{4, 3};
  int m [2][4];
  int md [2];
  int mv [2];
  int me [2];

  reg_bank_n #(.WIDTH(4), .NCH(4), .AW(2)) dut4 (
    .Clk(Clk), .Rst(Rst), .Mode(Mode), .LoadEn(LoadEn),
    .DataIn(DataIn), .ShiftIn(ShiftIn), .RdReq(RdReq),
    .RdAddr(RdAddr), .Regs(regs4), .ShiftOut(so4),
    .RdData(rd4), .RdValid(rv4), .AddrErr(ae4)
  );

  reg_bank_n #(.WIDTH(4), .NCH(3), .AW(2)) dut3 (
    .Clk(Clk), .Rst(Rst), .Mode(Mode), .LoadEn(LoadEn[2:0]),
    .DataIn(DataIn[11:0]), .ShiftIn(ShiftIn), .RdReq(RdReq),
    .RdAddr(RdAddr), .Regs(regs3), .ShiftOut(so3),
    .RdData(rd3), .RdValid(rv3), .AddrErr(ae3)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) m[k][i] = 0;
      md[k] = 0; mv[k] = 0; me[k] = 0;
    end
  endtask

  // Behaviour of one rising edge, from the current inputs
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int n;
      int pre [4];
      n = nch[k];
      pre = m[k];
      if (RdReq) begin
        mv[k] = 1;
        if (int'(RdAddr) >= n) begin
          md[k] = 0; me[k] = 1;
        end else begin
          md[k] = pre[RdAddr]; me[k] = 0;
        end
      end else begin
        mv[k] = 0; me[k] = 0;
      end
      case (Mode)
        2'b01:
          for (int i = 0; i < n; i++)
            if (LoadEn[i]) m[k][i] = int'(DataIn[4*i +: 4]);
        2'b10: begin
          for (int i = 1; i < n; i++) m[k][i] = pre[i-1];
          m[k][0] = int'(ShiftIn);
        end
        2'b11:
          for (int i = 0; i < n; i++) m[k][i] = 0;
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] pack(int k);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nch[k]; i++)
      r = r | (32'(m[k][i]) << (4*i));
    return r;
  endfunction

  task automatic check_all();
    chk("regs4", 32'(regs4), pack(0));
    chk("shout4", 32'(so4), 32'(m[0][3]));
    chk("rdata4", 32'(rd4), 32'(md[0]));
    chk("rvalid4", 32'(rv4), 32'(mv[0]));
    chk("aerr4", 32'(ae4), 32'(me[0]));
    chk("regs3", 32'(regs3), pack(1));
    chk("shout3", 32'(so3), 32'(m[1][2]));
    chk("rdata3", 32'(rd3), 32'(md[1]));
    chk("rvalid3", 32'(rv3), 32'(mv[1]));
    chk("aerr3", 32'(ae3), 32'(me[1]));
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse well away from any clock edge
  task automatic pulse_reset();
    Rst = 1'b1;
    #1;
    model_reset();
    chk("rst_regs4", 32'(regs4), 32'h0);
    chk("rst_rv4", 32'(rv4), 32'h0);
    chk("rst_ae4", 32'(ae4), 32'h0);
    check_all();
    #1;
    Rst = 1'b0;
  endtask

  task automatic load_all();
    Mode = 2'b01; LoadEn = 4'hF; DataIn = 16'h4321; RdReq = 1'b0;
    step();
    Mode = 2'b00; LoadEn = 4'h0;
  endtask

  initial begin
    Rst = 1'b1; Mode = 2'b00; LoadEn = '0; DataIn = '0;
    ShiftIn = '0; RdReq = 1'b0; RdAddr = '0;
    model_reset();
    #2;
    check_all();
    Rst = 1'b0;

    // load with a read in flight, then reset between edges
    Mode = 2'b01; LoadEn = 4'hF; DataIn = 16'h4321;
    RdReq = 1'b1; RdAddr = 2'd1;
    step();
    chk("load", 32'(regs4), 32'h4321);
    chk("load_rv", 32'(rv4), 32'h1);
    Mode = 2'b00; RdReq = 1'b0;
    pulse_reset();

    // masked load
    load_all();
    Mode = 2'b01; LoadEn = 4'b0101; DataIn = 16'hAAAA;
    step();
    chk("mask", 32'(regs4), 32'h4A2A);
    Mode = 2'b00; LoadEn = 4'h0;

    // shift chain
    load_all();
    Mode = 2'b10;
    for (int i = 0; i < 4; i++) begin
      ShiftIn = 4'(5 + i);
      chk("shout_pre", 32'(so4), 32'(4 - i));
      step();
    end
    chk("shift", 32'(regs4), 32'h5678);
    Mode = 2'b00;

    // read during clear
    load_all();
    Mode = 2'b11; RdReq = 1'b1; RdAddr = 2'd2;
    step();
    chk("rdw_data", 32'(rd4), 32'h3);
    chk("rdw_valid", 32'(rv4), 32'h1);
    chk("rdw_regs", 32'(regs4), 32'h0);
    Mode = 2'b00; RdReq = 1'b0;

    // out-of-range address on the 3-channel bank
    load_all();
    RdReq = 1'b1; RdAddr = 2'd3;
    step();
    chk("aerr_flag", 32'(ae3), 32'h1);
    chk("aerr_valid", 32'(rv3), 32'h1);
    chk("aerr_data", 32'(rd3), 32'h0);
    chk("aerr_regs", 32'(regs3), 32'h321);
    chk("aerr_in4", 32'(ae4), 32'h0);
    chk("aerr_rd4", 32'(rd4), 32'h4);
    RdReq = 1'b0;
    step();
    chk("aerr_clr", 32'(ae3), 32'h0);
    chk("aerr_rvclr", 32'(rv3), 32'h0);

    // back-to-back reads
    load_all();
    RdReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      RdAddr = 2'(i);
      step();
      chk("b2b_data", 32'(rd4), 32'(i + 1));
      chk("b2b_valid", 32'(rv4), 32'h1);
    end
    RdReq = 1'b0;
    step();
    chk("b2b_end", 32'(rv4), 32'h0);
    chk("b2b_hold", 32'(rd4), 32'h3);

    // random traffic with occasional async resets
    repeat (400) begin
      Mode = 2'($urandom);
      LoadEn = 4'($urandom);
      DataIn = 16'($urandom);
      ShiftIn = 4'($urandom);
      RdReq = 1'($urandom);
      RdAddr = 2'($urandom);
      if ($urandom_range(0, 40) == 0) pulse_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/reg_bank_n.md
Name: reg_bank_n

Overview:
Parametrised multi-channel register bank. It is the next generation of the fixed 4-channel clocked register bank. It holds NCH channels of WIDTH bits with per-channel load enables, a shift-chain mode, synchronous clear and an addressed registered readback port. It sits between the datapath function units (F outputs) and downstream consumers that need either all channels in parallel or one channel selected by address.

Parameters:
WIDTH, 4, bits per channel
NCH, 4, number of channels (>=2)
AW, 2, read address width; must satisfy 2**AW >= NCH
RESET_VAL, 0, value loaded into every channel on reset and on CLEAR (WIDTH bits)

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  asynchronous, active-high reset
Mode  input  2  00 HOLD, 01 LOAD, 10 SHIFT, 11 CLEAR
LoadEn  input  NCH  per-channel load enable, used only in LOAD
DataIn  input  NCH*WIDTH  channel i input at bits [i*WIDTH +: WIDTH]
ShiftIn  input  WIDTH  serial word into channel 0 in SHIFT
RdReq  input  1  readback request
RdAddr  input  AW  channel index to read
Regs  output  NCH*WIDTH  all channel contents, packed like DataIn, driven directly from the channel flops
ShiftOut  output  WIDTH  current content of channel NCH-1 (combinational from flops)
RdData  output  WIDTH  registered readback data
RdValid  output  1  one-cycle pulse, RdData valid
AddrErr  output  1  one-cycle pulse, RdAddr >= NCH on request

Behaviour:
- Reset (Rst=1, asynchronous, immediate): every channel = RESET_VAL; RdData=0; RdValid=0; AddrErr=0. This holds while Rst is high. The first rising edge after deassert acts normally.
- Channel update on rising edge, by Mode:
  - HOLD: all channels unchanged.
  - LOAD: channel i <= DataIn slice i if LoadEn[i]=1, else unchanged. LoadEn=0 is equivalent to HOLD.
  - SHIFT: ch0 <= ShiftIn; ch i <= ch i-1 for i=1..NCH-1. LoadEn is ignored. The old ch NCH-1 is lost and was visible on ShiftOut before the edge.
  - CLEAR: all channels <= RESET_VAL.
- Latency: Regs and ShiftOut reflect an update 1 cycle after the edge that samples the inputs. There is no combinational path from DataIn to Regs.
- Readback: when RdReq=1 at edge T, RdValid=1 for the cycle after T. RdData holds the channel value present before edge T (pre-update value), including when that channel is written at the same edge.
  - If RdAddr >= NCH: RdData=0, AddrErr=1, RdValid=1 in that same cycle.
  - RdReq=0: RdValid=0, AddrErr=0, RdData holds its last value.
  - Back-to-back requests give back-to-back RdValid pulses, one per request. There is no stall or backpressure.
- Readback is independent of Mode; a read during SHIFT or CLEAR is legal.
- Width rules: there is no arithmetic. Slices are exact WIDTH. RESET_VAL is truncated to WIDTH.
- Undefined Mode (X) is not supported. The bench must drive known values.

Test Plan:
- Reset mid-operation (WIDTH=4, NCH=4):
  - Stimulus: LOAD all with LoadEn=1111, DataIn=0x4321, then assert Rst asynchronously between edges.
  - Response: Regs=0x4321 after the load. Regs=0x0000, RdValid=0 and AddrErr=0 immediately on Rst, before any clock edge.
- Masked load:
  - Stimulus: Regs=0x4321, Mode=LOAD, LoadEn=0101, DataIn=0xAAAA.
  - Response: next cycle Regs=0x4A2A.
- Shift chain:
  - Stimulus: from Regs=0x4321, four SHIFT cycles with ShiftIn=5,6,7,8.
  - Response: ShiftOut sequence 4,3,2,1 before each edge. Final Regs=0x5678 (ch3=5, ch0=8).
- Read-during-write:
  - Stimulus: Regs=0x4321, same edge Mode=CLEAR, RdReq=1, RdAddr=2.
  - Response: next cycle RdValid=1, RdData=3, Regs=0x0000.
- Address error (NCH=3, AW=2):
  - Stimulus: RdReq=1, RdAddr=3.
  - Response: next cycle RdValid=1, AddrErr=1, RdData=0. Channels unaffected.
- Back-to-back reads:
  - Stimulus: RdReq held high 3 cycles with RdAddr=0,1,2 on Regs=0x4321, Mode=HOLD.
  - Response: RdValid high 3 consecutive cycles with RdData=1,2,3, then RdValid=0.
